// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player -- plays one note at a time from a sequencer.
//
// A new_note request latches a note code and a duration in beats, clears the
// phase accumulator and starts playing. Every beat tick (while play is high)
// takes one beat off the counter; when it reaches zero the block pulses
// note_done for one cycle and goes idle. While a non-rest note is sounding,
// each sample_tick advances the phase by step_in, the increment the external
// frequency ROM supplies for current_note. The phase wraps modulo
// 2^PHASE_W and feeds an external sine lookup.
//
// play low pauses the note: counter, FSM and phase hold, but new_note is
// still accepted.
//
// Optional feature, macro NOTE_GAP_EN:
//   When defined, a note that runs out of beats enters a silent GAP state and
//   waits for one more beat before pulsing note_done, so that back-to-back
//   notes are audibly separated. When undefined there is no GAP state and the
//   note goes straight from PLAY to DONE.
// -----------------------------------------------------------------------------
module note_player #(
  parameter int DUR_W   = 6,
  parameter int PHASE_W = 20
) (
  input  logic               clk,
  input  logic               reset,        // asynchronous, active low
  input  logic               play,
  input  logic               new_note,
  input  logic [5:0]         note,
  input  logic [DUR_W-1:0]   duration,
  input  logic               beat,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] step_in,
  output logic [5:0]         current_note,
  output logic               note_active,
  output logic [PHASE_W-1:0] phase,
  output logic               note_done
);

`ifdef NOTE_GAP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  localparam logic [DUR_W-1:0] CNT_ONE = DUR_W'(1);

  state_t               state_q, state_d;
  logic [5:0]           note_q, note_d;
  logic [DUR_W-1:0]     count_q, count_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 done_q, done_d;
  logic                 active;

  // Sounding only while playing, unpaused, not a rest and with beats left; a
  // zero-length note therefore never makes sound on its way to DONE.
  assign active = (state_q == PLAY) && play && (note_q != 6'd0) && (count_q != '0);

  // Next-state logic for the FSM, beat counter, latched note and phase.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    note_d  = note_q;
    count_d = count_q;
    phase_d = phase_q;
    done_d  = 1'b0;

    if (new_note) begin
      // A load wins over everything else in the same cycle, including a beat
      // (which is dropped) and a sample tick. Any note in progress is simply
      // abandoned, so it never reports note_done.
      note_d  = note;
      count_d = duration;
      phase_d = '0;
      state_d = PLAY;
    end else begin
      if (active && sample_tick) begin
        phase_d = phase_q + step_in;   // wraps naturally at PHASE_W bits
      end

      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        PLAY: begin
          if (play) begin
            if (count_q == '0) begin
              // Zero-length note: finish without consuming a beat.
              state_d = DONE;
              done_d  = 1'b1;
            end else if (beat) begin
              count_d = count_q - CNT_ONE;
              if (count_q == CNT_ONE) begin
`ifdef NOTE_GAP_EN
                state_d = GAP;
`else
                state_d = DONE;
                done_d  = 1'b1;
`endif
              end
            end
          end
        end

`ifdef NOTE_GAP_EN
        GAP: begin
          // Silent separation beat; phase is held because active is low.
          if (play && beat) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
`endif

        DONE: begin
          // Leave DONE unconditionally so note_done is exactly one cycle wide
          // even if play drops at that moment.
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register is given a reset value so an interrupted note
      // cannot leave stale state behind after reset is released.
      state_q <= IDLE;
      note_q  <= '0;
      count_q <= '0;
      phase_q <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q <= state_d;
      note_q  <= note_d;
      count_q <= count_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  assign current_note = note_q;
  assign note_active  = active;
  assign phase        = phase_q;
  assign note_done    = done_q;

endmodule

// File: tb/tb_note_player.sv
// -----------------------------------------------------------------------------
// tb_note_player -- directed self-checking bench for note_player.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same
// point, well away from the active edge. Build with +define+NOTE_GAP_EN to
// exercise the gap variant; the expectations adapt to it.
// -----------------------------------------------------------------------------
module tb_note_player;
  localparam int DUR_W   = 6;
  localparam int PHASE_W = 20;

  logic               clk = 1'b0;
  logic               reset;
  logic               play;
  logic               new_note;
  logic [5:0]         note;
  logic [DUR_W-1:0]   duration;
  logic               beat;
  logic               sample_tick;
  logic [PHASE_W-1:0] step_in;
  logic [5:0]         current_note;
  logic               note_active;
  logic [PHASE_W-1:0] phase;
  logic               note_done;

  int total = 0;
  int bad   = 0;

  note_player #(.DUR_W(DUR_W), .PHASE_W(PHASE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .new_note     (new_note),
    .note         (note),
    .duration     (duration),
    .beat         (beat),
    .sample_tick  (sample_tick),
    .step_in      (step_in),
    .current_note (current_note),
    .note_active  (note_active),
    .phase        (phase),
    .note_done    (note_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] n, input logic [DUR_W-1:0] d);
    note     = n;
    duration = d;
    new_note = 1'b1;
    step();
    new_note = 1'b0;
  endtask

  task automatic give_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
  endtask

  // Last beat of a note: note_done must be high for the one cycle after it
  // (after an extra silent beat in the gap variant), then low again.
  task automatic final_beat(input string tag);
    give_beat();
`ifdef NOTE_GAP_EN
    check({tag, "_gap_active"}, 32'(note_active), 32'd0);
    check({tag, "_gap_done"},   32'(note_done),   32'd0);
    give_beat();
`endif
    check({tag, "_done"}, 32'(note_done), 32'd1);
    step();
    check({tag, "_done_low"}, 32'(note_done), 32'd0);
  endtask

  initial begin
    logic [PHASE_W-1:0] wrap_seq [4];
    logic               seen_done;

    reset       = 1'b0;
    play        = 1'b0;
    new_note    = 1'b0;
    note        = '0;
    duration    = '0;
    beat        = 1'b0;
    sample_tick = 1'b0;
    step_in     = '0;

    // ---- reset state ----
    #2;
    check("rst_note",   32'(current_note), 32'd0);
    check("rst_active", 32'(note_active),  32'd0);
    check("rst_phase",  32'(phase),        32'd0);
    check("rst_done",   32'(note_done),    32'd0);
    step();
    reset = 1'b1;
    step();
    check("idle_done", 32'(note_done), 32'd0);

    // ---- note 5, three beats, plus phase wrap sequence ----
    play    = 1'b1;
    step_in = 20'h80000;
    load(6'd5, 6'd3);
    check("a_note",   32'(current_note), 32'd5);
    check("a_active", 32'(note_active),  32'd1);
    check("a_phase0", 32'(phase),        32'd0);
    check("a_done0",  32'(note_done),    32'd0);
    wrap_seq[0] = 20'h80000;
    wrap_seq[1] = 20'h00000;
    wrap_seq[2] = 20'h80000;
    wrap_seq[3] = 20'h00000;
    sample_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("a_wrap%0d", i), 32'(phase), 32'(wrap_seq[i]));
    end
    sample_tick = 1'b0;
    give_beat();
    check("a_b1_done", 32'(note_done), 32'd0);
    give_beat();
    check("a_b2_done",   32'(note_done),   32'd0);
    check("a_b2_active", 32'(note_active), 32'd1);
    final_beat("a");
    check("a_idle_active", 32'(note_active), 32'd0);

    // ---- rest note: silent, phase stays 0 ----
    step_in     = 20'h11111;
    sample_tick = 1'b1;
    load(6'd0, 6'd2);
    check("b_active", 32'(note_active), 32'd0);
    check("b_phase",  32'(phase),       32'd0);
    give_beat();
    check("b_b1_phase", 32'(phase),     32'd0);
    check("b_b1_done",  32'(note_done), 32'd0);
    final_beat("b");
    check("b_end_phase", 32'(phase), 32'd0);
    sample_tick = 1'b0;

    // ---- duration 0: immediate finish, no sound ----
    load(6'd3, 6'd0);
    check("e_active", 32'(note_active), 32'd0);
    check("e_done0",  32'(note_done),   32'd0);
    step();
    check("e_done", 32'(note_done), 32'd1);
    step();
    check("e_done_low", 32'(note_done), 32'd0);

    // ---- pause for 10 beats mid-note ----
    step_in = 20'h00100;
    load(6'd7, 6'd3);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("c_phase", 32'(phase), 32'h100);
    give_beat();
    check("c_b1_done", 32'(note_done), 32'd0);
    play        = 1'b0;
    beat        = 1'b1;
    sample_tick = 1'b1;
    repeat (10) step();
    check("c_frz_phase",  32'(phase),        32'h100);
    check("c_frz_active", 32'(note_active),  32'd0);
    check("c_frz_done",   32'(note_done),    32'd0);
    check("c_frz_note",   32'(current_note), 32'd7);
    beat        = 1'b0;
    sample_tick = 1'b0;
    play        = 1'b1;
    step();
    check("c_resume_active", 32'(note_active), 32'd1);
    check("c_resume_phase",  32'(phase),       32'h100);
    give_beat();
    check("c_b2_done", 32'(note_done), 32'd0);
    final_beat("c");

    // ---- new_note accepted while paused ----
    play = 1'b0;
    load(6'd8, 6'd1);
    check("c2_note",   32'(current_note), 32'd8);
    check("c2_active", 32'(note_active),  32'd0);
    play = 1'b1;
    #1;
    check("c2_active_play", 32'(note_active), 32'd1);
    final_beat("c2");

    // ---- new_note coinciding with a beat: the beat is not counted ----
    load(6'd9, 6'd4);
    give_beat();
    note     = 6'd10;
    duration = 6'd2;
    new_note = 1'b1;
    beat     = 1'b1;
    step();
    new_note = 1'b0;
    beat     = 1'b0;
    check("d_note", 32'(current_note), 32'd10);
    check("d_done", 32'(note_done),    32'd0);
    give_beat();
    check("d_b1_done", 32'(note_done), 32'd0);
    final_beat("d");

    // ---- reset mid-note: outputs cleared at once, no note_done ----
    step_in = 20'h00100;
    load(6'd11, 6'd5);
    sample_tick = 1'b1;
    give_beat();
    check("r_pre_phase", 32'(phase), 32'h100);
    reset = 1'b0;
    #1;
    check("r_async_note",   32'(current_note), 32'd0);
    check("r_async_active", 32'(note_active),  32'd0);
    check("r_async_phase",  32'(phase),        32'd0);
    check("r_async_done",   32'(note_done),    32'd0);
    beat = 1'b1;
    repeat (3) step();
    check("r_hold_phase", 32'(phase),     32'd0);
    check("r_hold_done",  32'(note_done), 32'd0);
    beat        = 1'b0;
    sample_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      give_beat();
      if (note_done) seen_done = 1'b1;
    end
    check("r_after_done",   32'(seen_done),    32'd0);
    check("r_after_note",   32'(current_note), 32'd0);
    check("r_after_active", 32'(note_active),  32'd0);

    // ---- duration 1: active drops at the first beat ----
    step_in     = 20'h00040;
    sample_tick = 1'b1;
    load(6'd12, 6'd1);
    check("g_active", 32'(note_active), 32'd1);
    give_beat();
    check("g_b1_active", 32'(note_active), 32'd0);
`ifdef NOTE_GAP_EN
    check("g_b1_done", 32'(note_done), 32'd0);
    step();
    check("g_gap_phase", 32'(phase), 32'h40);
    give_beat();
`endif
    check("g_done", 32'(note_done), 32'd1);
    step();
    check("g_done_low", 32'(note_done), 32'd0);
    sample_tick = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have parameter DUR_W, default 6: width of note duration in beats.
REQ-002 SHALL have parameter PHASE_W, default 20: width of the phase accumulator and step.
REQ-003 SHALL have port clk, input, 1: single clock; every flop is in this domain.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port play, input, 1: high = run; low = pause (freeze).
REQ-006 SHALL have port new_note, input, 1: one-cycle request to load note/duration.
REQ-007 SHALL have port note, input, 6: note code; 0 = rest.
REQ-008 SHALL have port duration, input, DUR_W: note length in beats.
REQ-009 SHALL have port beat, input, 1: one-cycle beat tick.
REQ-010 SHALL have port sample_tick, input, 1: one-cycle audio sample strobe.
REQ-011 SHALL have port step_in, input, PHASE_W: phase increment for current_note, from the external frequency ROM.
REQ-012 SHALL have port current_note, output, 6: latched note code; addresses the frequency ROM.
REQ-013 SHALL have port note_active, output, 1: high while sounding a non-rest note.
REQ-014 SHALL have port phase, output, PHASE_W: phase accumulator; feeds the sine lookup.
REQ-015 SHALL have port note_done, output, 1: one-cycle pulse when the note finishes.

Function
REQ-016 SHALL use FSM states IDLE, PLAY, GAP (only when NOTE_GAP_EN is defined) and DONE.
REQ-017 SHALL, in any state, on new_note=1 at edge N: latch note into current_note and duration into the beat counter, clear phase to 0, enter PLAY at N+1.
REQ-018 SHALL, when new_note arrives during PLAY or GAP, abandon the old note without pulsing note_done for it.
REQ-019 SHALL, in PLAY with play=1 and beat=1, decrement the beat counter by 1.
REQ-020 SHALL, when a decrement makes the counter 0, move to DONE (or to GAP under NOTE_GAP_EN).
REQ-021 SHALL, in DONE, drive note_done=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL treat duration=0 as an immediate finish: PLAY goes to DONE on the next edge, with no beat consumed and no sound.
REQ-023 SHALL let new_note take priority over a beat arriving in the same cycle; that beat is not counted.
REQ-024 SHALL, when play=0, freeze the counter, FSM and phase, and still accept new_note.
REQ-025 SHALL drive note_active=1 only in PLAY with play=1 and current_note!=0.
REQ-026 SHALL, on sample_tick while note_active=1, set phase <= phase + step_in modulo 2^PHASE_W (wraps, no saturation).
REQ-027 SHALL otherwise hold phase.
REQ-028 SHALL keep note_done low in every state except DONE.

Reset
REQ-029 SHALL, while reset=0, immediately (asynchronously) force: state IDLE, current_note=0, beat counter=0, phase=0, note_active=0, note_done=0.
REQ-030 SHALL, when reset asserts mid-note, abandon the note with no note_done pulse; after release the block waits in IDLE for new_note.

Configuration
REQ-031 SHALL, with NOTE_GAP_EN defined: when the counter reaches 0, enter GAP with note_active=0 and phase held, wait for one further beat (gated by play), then enter DONE.
REQ-032 SHALL, without NOTE_GAP_EN: have no GAP state; PLAY goes directly to DONE.

Verification
REQ-033 SHALL cover: new_note with note=5, duration=3, play=1, three beats -> note_done pulses for one cycle, one cycle after the third beat edge.
REQ-034 SHALL cover: note=0, duration=2 -> note_active stays 0, phase stays 0, note_done after two beats.
REQ-035 SHALL cover: step_in=0x80000, 4 sample_ticks from phase 0 -> phase 0x80000, 0x00000, 0x80000, 0x00000.
REQ-036 SHALL cover: play=0 for 10 beats mid-note -> counter and phase unchanged; play=1 -> resumes with the remaining beat count.
REQ-037 SHALL cover: new_note coinciding with a beat, then reset=0 mid-note -> new duration loaded intact; all outputs 0 during reset; no note_done.
REQ-038 SHALL cover: NOTE_GAP_EN defined, duration=1 -> note_active falls at the first beat, note_done follows the second beat.
